// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit combinational ALU: decodes opcodes,
// drives the ALU operands, writes results back to the accumulator and serves OUT requests.
module alu_sequencer #(
    parameter logic [7:0] ACC_RESET    = 8'h00,
    parameter int         RETIRE_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [11:0]             instr,
    output logic [7:0]              alu_a,
    output logic [7:0]              alu_b,
    output logic [3:0]              alu_operation,
    input  logic [7:0]              alu_sum,
    output logic [7:0]              acc,
    output logic                    zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    illegal,
    output logic [RETIRE_WIDTH-1:0] retired
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        OUTPUT
    } state_t;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b0111;
    localparam logic [3:0] OP_OUT = 4'b1000;

    localparam logic [RETIRE_WIDTH-1:0] RETIRE_ONE = 1;

    state_t     state;
    logic [3:0] opcode;
    logic [7:0] imm;

    assign opcode      = instr[11:8];
    assign imm         = instr[7:0];
    assign instr_ready = (state == IDLE);

    // Single-process FSM; illegal defaults low so it can only ever pulse for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= ACC_RESET;
            alu_a         <= 8'h00;
            alu_b         <= 8'h00;
            alu_operation <= 4'b0000;
            zero          <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= 8'h00;
            illegal       <= 1'b0;
            retired       <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        case (opcode)
                            OP_NOP: begin
                                retired <= retired + RETIRE_ONE;
                            end
                            OP_ADD, OP_SUB, OP_OR, OP_AND, OP_XOR, OP_NOT: begin
                                alu_a         <= acc;
                                alu_b         <= imm;
                                alu_operation <= opcode;
                                state         <= EXEC;
                            end
                            OP_LDI: begin
                                acc     <= imm;
                                retired <= retired + RETIRE_ONE;
                            end
                            OP_OUT: begin
                                out_data  <= acc;
                                out_valid <= 1'b1;
                                state     <= OUTPUT;
                            end
                            default: begin
                                illegal <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    // The ALU has had a full cycle to settle on the registered operands.
                    acc           <= alu_sum;
                    zero          <= (alu_sum == 8'h00);
                    alu_operation <= 4'b0000;
                    retired       <= retired + RETIRE_ONE;
                    state         <= IDLE;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        retired   <= retired + RETIRE_ONE;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
